// File: rtl/oport_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : oport_rr_arbiter
//  Description : Per-output-port round-robin scheduler for the 5-port NoC
//                router. Picks one of NREQ input buffers per cycle, gates every
//                grant on downstream credit and drives buffer pop / xbar select.
//                Optional build macro OPORT_ARB_STATS_EN adds stall_cnt_o, a
//                saturating count of credit-starved cycles with pending requests.
//  Revision    : 1.0 - initial release
// ============================================================================
module oport_rr_arbiter #(
    parameter int NREQ    = 5,
    parameter int CREDITS = 4,
    parameter int CW      = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_i,
    input  logic            credit_incr_i,
    output logic [NREQ-1:0] grant_o,
    output logic            valid_o,
    output logic [CW-1:0]   credit_cnt_o,
    output logic            ovf_err_o
`ifdef OPORT_ARB_STATS_EN
    ,
    output logic [15:0]     stall_cnt_o
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GRANT  = 2'd1;
    localparam logic [1:0] S_NOCRED = 2'd2;

    localparam logic [CW:0]   CRED_EXT = (CW+1)'(CREDITS);
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
    localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

    logic [1:0]      state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;

    logic            grant_any_w;
    logic [NREQ-1:0] elig_w;
    logic [CW:0]     cnt_sum_w;
    logic            avail_w;
    logic            do_grant_w;
    logic            win_found_w;
    logic [PW-1:0]   win_idx_w;
    logic [PW-1:0]   cand_idx_w;
    int              cand_w;

    assign grant_any_w = |grant_q;
    // The buffer granted this cycle still shows its pre-pop request, so mask it.
    assign elig_w      = req_i & ~grant_q;

    // Credit arithmetic carried one bit wider so an overflowing increment is visible.
    always_comb begin
        cnt_sum_w = {1'b0, cnt_q} - {{CW{1'b0}}, grant_any_w} + {{CW{1'b0}}, credit_incr_i};
        avail_w   = (cnt_sum_w != '0);
        ovf_d     = ovf_q | (cnt_sum_w > CRED_EXT);
        cnt_d     = (cnt_sum_w > CRED_EXT) ? CRED_MAX : cnt_sum_w[CW-1:0];
    end

    // Round-robin search: first eligible requester at or above ptr, wrapping.
    always_comb begin
        win_found_w = 1'b0;
        win_idx_w   = '0;
        cand_w      = 0;
        cand_idx_w  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_w = int'(ptr_q) + k;
            if (cand_w >= NREQ) begin
                cand_w = cand_w - NREQ;
            end
            cand_idx_w = PW'(cand_w);
            if (!win_found_w && elig_w[cand_idx_w]) begin
                win_found_w = 1'b1;
                win_idx_w   = cand_idx_w;
            end
        end
    end

    assign do_grant_w = ((state_q == S_IDLE) || (state_q == S_GRANT))
                        && win_found_w && avail_w;

    // State, grant, pointer and credit registers; reset drops any live grant.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= CRED_MAX;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic: NOCRED waits for a returned credit before rearbitrating.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_GRANT: begin
                if (win_found_w && avail_w) begin
                    state_d = S_GRANT;
                end else if (!avail_w) begin
                    state_d = S_NOCRED;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_NOCRED: begin
                if (credit_incr_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: one-hot grant for the winner and pointer advance past it.
    always_comb begin
        grant_d = '0;
        ptr_d   = ptr_q;
        if (do_grant_w) begin
            grant_d = {{(NREQ-1){1'b0}}, 1'b1} << win_idx_w;
            ptr_d   = (win_idx_w == LAST_IDX) ? '0 : win_idx_w + PW'(1);
        end
    end

    assign grant_o      = grant_q;
    assign valid_o      = grant_any_w;
    assign credit_cnt_o = cnt_q;
    assign ovf_err_o    = ovf_q;

`ifdef OPORT_ARB_STATS_EN
    logic [15:0] stall_q;

    // Saturating count of cycles starved of credit while requests are waiting.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q <= '0;
        end else if ((state_q == S_NOCRED) && (|req_i) && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_q;
`else
    // Statistics build option disabled: no stall counter is present.
`endif

endmodule
`default_nettype wire

// File: tb/tb_oport_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_oport_rr_arbiter
//  Description : Scoreboard testbench for oport_rr_arbiter. Stimulus pushes
//                the expected grant vectors; a negedge monitor pops and
//                compares on every valid_o cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_oport_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] req_i = '0;
    logic       credit_incr_i = 1'b0;
    logic [4:0] grant_o;
    logic       valid_o;
    logic [2:0] credit_cnt_o;
    logic       ovf_err_o;
`ifdef OPORT_ARB_STATS_EN
    logic [15:0] stall_cnt_o;
`endif

    oport_rr_arbiter #(.NREQ(5), .CREDITS(4), .CW(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req_i),
        .credit_incr_i(credit_incr_i),
        .grant_o      (grant_o),
        .valid_o      (valid_o),
        .credit_cnt_o (credit_cnt_o),
        .ovf_err_o    (ovf_err_o)
`ifdef OPORT_ARB_STATS_EN
        ,
        .stall_cnt_o  (stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         valid_total = 0;
    int         v0;
    logic [4:0] exp_q[$];
    logic [4:0] mon_exp;

    // Monitor: every presented flit must match the next expected grant.
    always @(negedge clk) begin
        checks++;
        if (valid_o !== (|grant_o)) begin
            errors++;
            $display("FAIL valid_eq_or_grant: valid_o=%b grant_o=%b", valid_o, grant_o);
        end
        if (valid_o === 1'b1) begin
            valid_total++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL grant_unexpected: actual %b, required no grant", grant_o);
            end else begin
                mon_exp = exp_q.pop_front();
                if (grant_o !== mon_exp) begin
                    errors++;
                    $display("FAIL grant_seq: actual %b, required %b", grant_o, mon_exp);
                end
            end
            checks++;
            if (credit_cnt_o == 3'd0) begin
                errors++;
                $display("FAIL credit_underflow: grant issued with credit_cnt_o=0");
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h, required %0h", name, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: reset held two cycles
        step(2);
        chk("rst_grant", 32'(grant_o), 32'h0);
        chk("rst_valid", 32'(valid_o), 32'h0);
        chk("rst_cnt",   32'(credit_cnt_o), 32'd4);
        chk("rst_ovf",   32'(ovf_err_o), 32'h0);
        rst = 1'b1;

        // 2: fairness, all requesting, credit returned every grant cycle
        v0 = valid_total;
        exp_q.push_back(5'b00001); exp_q.push_back(5'b00010);
        exp_q.push_back(5'b00100); exp_q.push_back(5'b01000);
        exp_q.push_back(5'b10000); exp_q.push_back(5'b00001);
        req_i = 5'b11111;
        step(1);
        credit_incr_i = 1'b1;
        step(5);
        req_i = 5'b00000;
        step(1);
        credit_incr_i = 1'b0;
        step(1);
        chk("fair_count", 32'(valid_total - v0), 32'd6);
        chk("fair_drain", 32'(exp_q.size()), 32'd0);
        chk("fair_cnt",   32'(credit_cnt_o), 32'd4);
        chk("fair_ovf",   32'(ovf_err_o), 32'h0);

        // 3: single requester gets every other cycle
        v0 = valid_total;
        repeat (5) exp_q.push_back(5'b00100);
        req_i = 5'b00100;
        repeat (5) begin
            step(1);
            chk("single_on", 32'(valid_o), 32'h1);
            credit_incr_i = 1'b1;
            step(1);
            chk("single_off", 32'(valid_o), 32'h0);
            credit_incr_i = 1'b0;
        end
        req_i = 5'b00000;
        step(2);
        chk("single_duty",  32'(valid_total - v0), 32'd5);
        chk("single_drain", 32'(exp_q.size()), 32'd0);

        // 4: credit exhaustion, then one credit buys exactly one grant
        exp_q.push_back(5'b00001); exp_q.push_back(5'b00010);
        exp_q.push_back(5'b00001); exp_q.push_back(5'b00010);
        req_i = 5'b00011;
        step(5);
        chk("exh_grant0", 32'(grant_o), 32'h0);
        chk("exh_cnt0",   32'(credit_cnt_o), 32'd0);
        step(3);
        chk("exh_stalled", 32'(valid_o), 32'h0);
        chk("exh_drain",   32'(exp_q.size()), 32'd0);
        exp_q.push_back(5'b00001);
        credit_incr_i = 1'b1;
        step(1);
        credit_incr_i = 1'b0;
        chk("credit_wait",  32'(valid_o), 32'h0);
        chk("credit_cnt1",  32'(credit_cnt_o), 32'd1);
        step(1);
        chk("credit_grant", 32'(grant_o), 32'b00001);
        step(1);
        chk("credit_spent", 32'(valid_o), 32'h0);
        chk("credit_cnt0",  32'(credit_cnt_o), 32'd0);
        step(2);
        chk("credit_once",  32'(valid_o), 32'h0);
        req_i = 5'b00000;
        credit_incr_i = 1'b1;
        step(4);
        credit_incr_i = 1'b0;
        step(1);
        chk("refill_cnt", 32'(credit_cnt_o), 32'd4);
        chk("refill_ovf", 32'(ovf_err_o), 32'h0);

        // 5: simultaneous decrement/increment, then overflow at full count
        exp_q.push_back(5'b00100); exp_q.push_back(5'b00100);
        req_i = 5'b00100;
        step(1);
        req_i = 5'b00000;
        step(1);
        chk("sim_cnt3", 32'(credit_cnt_o), 32'd3);
        req_i = 5'b00100;
        step(1);
        credit_incr_i = 1'b1;
        req_i = 5'b00000;
        step(1);
        chk("sim_unchanged", 32'(credit_cnt_o), 32'd3);
        chk("sim_ovf0",      32'(ovf_err_o), 32'h0);
        step(1);
        chk("sim_cnt4", 32'(credit_cnt_o), 32'd4);
        chk("sim_ovf1", 32'(ovf_err_o), 32'h0);
        step(1);
        credit_incr_i = 1'b0;
        chk("ovf_cnt_held", 32'(credit_cnt_o), 32'd4);
        chk("ovf_set",      32'(ovf_err_o), 32'h1);
        step(3);
        chk("ovf_sticky", 32'(ovf_err_o), 32'h1);
        chk("sim_drain",  32'(exp_q.size()), 32'd0);

        // 6: reset during a grant with two credits left
        repeat (3) exp_q.push_back(5'b01000);
        req_i = 5'b01000;
        step(5);
        chk("pre_rst_valid", 32'(valid_o), 32'h1);
        chk("pre_rst_cnt",   32'(credit_cnt_o), 32'd2);
        rst = 1'b0;
        step(1);
        chk("mid_rst_grant", 32'(grant_o), 32'h0);
        chk("mid_rst_cnt",   32'(credit_cnt_o), 32'd4);
        chk("mid_rst_ovf",   32'(ovf_err_o), 32'h0);
        rst = 1'b1;
        req_i = 5'b11000;
        exp_q.push_back(5'b01000);
        step(1);
        chk("rst_lowest", 32'(grant_o), 32'b01000);
        req_i = 5'b00000;
        step(2);
        chk("rst_drain", 32'(exp_q.size()), 32'd0);

`ifdef OPORT_ARB_STATS_EN
        // Stall statistics: 10 credit-starved cycles with a pending request
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        repeat (4) exp_q.push_back(5'b00001);
        req_i = 5'b00001;
        step(8);
        chk("stall_start", 32'(stall_cnt_o), 32'd0);
        step(10);
        chk("stall_10",    32'(stall_cnt_o), 32'd10);
        chk("stall_drain", 32'(exp_q.size()), 32'd0);
        rst = 1'b0;
        step(1);
        chk("stall_clear", 32'(stall_cnt_o), 32'd0);
        rst = 1'b1;
        req_i = 5'b00000;
        step(2);
`endif

        chk("final_drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
